// File: rtl/bus_drvr_fifo.sv
// Per-driver port buffer: TX FIFO toward the bus arbiter (pndng/pop/D_pop),
// RX FIFO from the arbiter (push/D_push). Both first-word-fall-through.
module bus_drvr_fifo #(
  parameter int bits  = 32,
  parameter int depth = 8,
  localparam int cw   = $clog2(depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  // client -> TX FIFO
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [bits-1:0] tx_data,
  // TX FIFO -> arbiter
  output logic            pndng,
  input  logic            pop,
  output logic [bits-1:0] D_pop,
  // arbiter -> RX FIFO
  input  logic            push,
  input  logic [bits-1:0] D_push,
  // RX FIFO -> client
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [bits-1:0] rx_data,
  // status
  input  logic            clr_ovf,
  output logic            rx_ovf,
  output logic            pop_err,
  output logic [cw-1:0]   tx_count,
  output logic [cw-1:0]   rx_count
);

  localparam int aw = cw - 1;
  localparam logic [cw-1:0] depth_c = cw'(depth);

  // Pointers carry one extra MSB so that wptr - rptr spans 0..depth.
  logic [cw-1:0]   r_tx_wptr, r_tx_rptr;
  logic [cw-1:0]   r_rx_wptr, r_rx_rptr;
  logic            r_rx_ovf, r_pop_err;
  logic [bits-1:0] r_tx_mem [depth];
  logic [bits-1:0] r_rx_mem [depth];

  logic w_tx_wr, w_tx_rd, w_rx_wr, w_rx_rd, w_rx_full, w_rx_drop;

  // Occupancy and status come purely from registered pointers.
  assign tx_count  = r_tx_wptr - r_tx_rptr;
  assign rx_count  = r_rx_wptr - r_rx_rptr;
  assign tx_ready  = (tx_count != depth_c);
  assign pndng     = (tx_count != '0);
  assign rx_valid  = (rx_count != '0);
  assign w_rx_full = (rx_count == depth_c);
  assign rx_ovf    = r_rx_ovf;
  assign pop_err   = r_pop_err;

  // Fall-through heads addressed by the registered read pointers.
  assign D_pop   = r_tx_mem[r_tx_rptr[aw-1:0]];
  assign rx_data = r_rx_mem[r_rx_rptr[aw-1:0]];

  // Accepted transfers; a full RX still takes a push if the client reads
  // in the same cycle, otherwise the word is dropped.
  assign w_tx_wr   = tx_valid && tx_ready;
  assign w_tx_rd   = pop && pndng;
  assign w_rx_rd   = rx_ready && rx_valid;
  assign w_rx_wr   = push && (!w_rx_full || w_rx_rd);
  assign w_rx_drop = push && !w_rx_wr;

  // Pointer and sticky-flag state; reset overrides every same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_ovf  <= 1'b0;
      r_pop_err <= 1'b0;
    end else begin
      if (w_tx_wr) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_rd) r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_rx_wr) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_rd) r_rx_rptr <= r_rx_rptr + 1'b1;
      if (pop && !pndng) r_pop_err <= 1'b1;
      // a new overflow wins over a same-cycle clear
      if (w_rx_drop)    r_rx_ovf <= 1'b1;
      else if (clr_ovf) r_rx_ovf <= 1'b0;
    end
  end

  // Storage arrays are never reset; only accepted writes touch them.
  always_ff @(posedge clk) begin
    if (w_tx_wr && !reset) r_tx_mem[r_tx_wptr[aw-1:0]] <= tx_data;
    if (w_rx_wr && !reset) r_rx_mem[r_rx_wptr[aw-1:0]] <= D_push;
  end

endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Self-checking bench for bus_drvr_fifo: directed steps plus a random phase,
// all compared against queue-based reference FIFOs.
module tb_bus_drvr_fifo;

  localparam int BITS  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset, tx_valid, pop, push, rx_ready, clr_ovf;
  logic [BITS-1:0] tx_data, D_push;
  logic            tx_ready, pndng, rx_valid, rx_ovf, pop_err;
  logic [BITS-1:0] D_pop, rx_data;
  logic [CW-1:0]   tx_count, rx_count;

  bus_drvr_fifo #(.bits(BITS), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .clr_ovf(clr_ovf), .rx_ovf(rx_ovf), .pop_err(pop_err),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  // reference model
  logic [BITS-1:0] txq[$];
  logic [BITS-1:0] rxq[$];
  bit              m_ovf, m_perr, m_txw;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // compare every output against the model (heads only when non-empty)
  task automatic check_all(input string tag);
    check({tag, ".tx_ready"}, 32'(tx_ready), 32'(txq.size() < DEPTH));
    check({tag, ".pndng"},    32'(pndng),    32'(txq.size() > 0));
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'(rxq.size() > 0));
    check({tag, ".tx_count"}, 32'(tx_count), 32'(txq.size()));
    check({tag, ".rx_count"}, 32'(rx_count), 32'(rxq.size()));
    check({tag, ".rx_ovf"},   32'(rx_ovf),   32'(m_ovf));
    check({tag, ".pop_err"},  32'(pop_err),  32'(m_perr));
    if (txq.size() > 0) check({tag, ".D_pop"},   D_pop,   txq[0]);
    if (rxq.size() > 0) check({tag, ".rx_data"}, rx_data, rxq[0]);
  endtask

  // one clock: model decides from pre-edge state, then both advance
  task automatic cycle();
    bit txw, txr, rxw, rxr, drop, perr;
    txw  = tx_valid && (txq.size() < DEPTH);
    txr  = pop && (txq.size() > 0);
    perr = pop && (txq.size() == 0);
    rxr  = rx_ready && (rxq.size() > 0);
    rxw  = push && ((rxq.size() < DEPTH) || rxr);
    drop = push && !rxw;
    @(posedge clk);
    if (reset) begin
      txq.delete(); rxq.delete(); m_ovf = 0; m_perr = 0; m_txw = 0;
    end else begin
      if (txr) void'(txq.pop_front());
      if (txw) txq.push_back(tx_data);
      if (rxr) void'(rxq.pop_front());
      if (rxw) rxq.push_back(D_push);
      if (perr) m_perr = 1;
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_txw = txw;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    tx_valid = 0; pop = 0; push = 0; rx_ready = 0; clr_ovf = 0; reset = 0;
  endtask

  initial begin
    bit pending9;
    reset = 1; tx_valid = 1; push = 1; pop = 0; rx_ready = 0; clr_ovf = 0;
    tx_data = 32'hDEAD0001; D_push = 32'hDEAD0002;

    // reset with writes requested
    @(negedge clk);
    cycle(); cycle();
    idle();
    check_all("reset");
    check("reset.tx_ready_c", 32'(tx_ready), 32'd1);

    // TX fill: 9 offered, 8 accepted
    for (int i = 1; i <= 9; i++) begin
      tx_valid = 1; tx_data = 32'(i);
      cycle();
      check_all("tx_fill");
    end
    check("tx_full.tx_ready", 32'(tx_ready), 32'd0);
    check("tx_full.count", 32'(tx_count), 32'd8);

    // TX drain: 9 pops, word 9 enters once a slot frees
    pending9 = 1;
    for (int i = 1; i <= 9; i++) begin
      tx_valid = pending9; pop = 1;
      check("tx_drain.D_pop", D_pop, 32'(i));
      cycle();
      if (m_txw) pending9 = 0;
      check_all("tx_drain");
    end
    idle();
    check("tx_drain.pndng_end", 32'(pndng), 32'd0);

    // write + pop on empty: pop ignored, pop_err set
    tx_valid = 1; pop = 1; tx_data = 32'hA5A5A5A5;
    cycle();
    idle();
    check("tx_empty.pop_err", 32'(pop_err), 32'd1);
    check("tx_empty.D_pop", D_pop, 32'hA5A5A5A5);
    check_all("tx_empty");
    pop = 1;
    cycle();
    idle();
    check("tx_empty.count0", 32'(tx_count), 32'd0);

    // RX overflow: 9 pushes with no reads
    for (int i = 0; i < 9; i++) begin
      push = 1; D_push = 32'h100 + 32'(i);
      cycle();
      check_all("rx_fill");
    end
    idle();
    check("rx_ovf.count", 32'(rx_count), 32'd8);
    check("rx_ovf.flag", 32'(rx_ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx_ready = 1;
      check("rx_ovf.data", rx_data, 32'h100 + 32'(i));
      cycle();
    end
    idle();
    // clear alone
    clr_ovf = 1;
    cycle();
    idle();
    check("clr_ovf.alone", 32'(rx_ovf), 32'd0);

    // 9th push coincides with a read: no overflow
    for (int i = 0; i < 9; i++) begin
      push = 1; D_push = 32'h100 + 32'(i); rx_ready = (i == 8);
      cycle();
      check_all("rx_fill_rd");
    end
    idle();
    check("rx_noovf.flag", 32'(rx_ovf), 32'd0);
    check("rx_noovf.count", 32'(rx_count), 32'd8);
    // overflow, then overflow + clear same cycle, then clear alone
    push = 1; D_push = 32'h200;
    cycle();
    check("clr_prec.set", 32'(rx_ovf), 32'd1);
    clr_ovf = 1; D_push = 32'h201;
    cycle();
    idle();
    check("clr_prec.keep", 32'(rx_ovf), 32'd1);
    clr_ovf = 1;
    cycle();
    idle();
    check("clr_prec.clear", 32'(rx_ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rx_ready = 1;
      check("rx_keep.data", rx_data, 32'h101 + 32'(i));
      cycle();
    end
    idle();
    check_all("rx_drained");

    // wrap-around at tx_count=3 with reset at cycle 10
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1; tx_data = 32'h3000 + 32'(i);
      push = 1; D_push = 32'h4000 + 32'(i);
      cycle();
    end
    idle();
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1; pop = 1; tx_data = $urandom; reset = (i == 10);
      cycle();
      check_all("wrap");
      if (i < 10) check("wrap.count3", 32'(tx_count), 32'd3);
      if (i == 10) begin
        check("wrap.rst_tx", 32'(tx_count), 32'd0);
        check("wrap.rst_rx", 32'(rx_count), 32'd0);
      end
    end
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tx_valid = $urandom_range(0, 1) == 1;
      pop      = $urandom_range(0, 2) != 0;
      push     = $urandom_range(0, 1) == 1;
      rx_ready = $urandom_range(0, 2) == 0;
      clr_ovf  = $urandom_range(0, 15) == 0;
      reset    = $urandom_range(0, 63) == 0;
      tx_data  = $urandom;
      D_push   = $urandom;
      cycle();
      check_all("rand");
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
